cpu_ctrl_fsm: RTL and testbench

- Multi-cycle control unit that sequences the 5-bit program counter, instruction register, accumulator and a shared instruction/data memory port.
- Runs FETCH -> DECODE -> MEM -> WB per instruction:
  - pulses the PC enable once per fetched instruction;
  - requests a PC load for jumps;
  - arbitrates the single memory port between instruction fetch (PC address) and data access (IR address field).
- Adds a bounded memory wait-state handshake with timeout.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/cpu_ctrl_fsm.sv | 174 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: state encodings,
// opcode values and ALU operation codes, plus the opcode-to-ALU mapping.
package cpu_pkg;

    // Controller states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b101
    } state_e;

    // Instruction opcodes (IR bits [7:5]).
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    // ALU operation select driven to the datapath.
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Opcodes that never reach the accumulator (STA, JMP, ...) fall back to
    // ADD so alu_op is always a defined value while the op register is shown.
    function automatic logic [1:0] alu_of_op(input logic [2:0] op);
        logic [1:0] alu;
        case (op)
            OP_ADD:  alu = ALU_ADD;
            OP_SUB:  alu = ALU_SUB;
            OP_AND:  alu = ALU_AND;
            OP_LDA:  alu = ALU_PASS;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter. Counts cycles spent waiting for the memory to
// complete; clear has priority over enable. The count saturates at WAIT_MAX
// and timeout_o is high while the count equals WAIT_MAX.
module mem_wait_timer
    import cpu_pkg::*;
#(
    parameter int CW       = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(WAIT_MAX);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear on request, otherwise step while enabled and below max.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX_COUNT)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = (count_q == MAX_COUNT);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control unit. Sequences FETCH -> DECODE -> MEM -> WB,
// arbitrates the single memory port between PC (fetch) and IR address field
// (data), and faults into HALT when memory fails to answer within WAIT_MAX
// cycles.
//
// Memory handshake: mem_rd / mem_wr are held as long as the request is
// outstanding; the transfer completes in the cycle mem_ready is sampled high,
// and the controller moves on at the following edge. mem_ready in the same
// cycle the wait counter reaches WAIT_MAX still counts as completion.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int OPW      = 3,
    parameter int WAIT_MAX = 15,
    parameter int CW       = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] ir_op,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           pc_load,
    output logic           ir_load,
    output logic           addr_sel,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           acc_load,
    output logic [1:0]     alu_op,
    output logic           halt,
    output logic           bus_err,
    output logic [2:0]     state
);

    state_e         state_q;
    state_e         state_d;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] op_d;
    logic           bus_err_q;
    logic           bus_err_d;

    logic           wait_en;
    logic           wait_clear;
    logic           wait_timeout;

    // Wait counter restarts on every state change so each FETCH/MEM visit
    // gets a full WAIT_MAX budget.
    assign wait_clear = (state_d != state_q);

    mem_wait_timer #(
        .CW       (CW),
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clear_i   (wait_clear),
        .en_i      (wait_en),
        .timeout_o (wait_timeout)
    );

    // State, latched opcode and fault flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state logic, opcode capture and timeout fault detection.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        bus_err_d = bus_err_q;
        wait_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_en = 1'b1;
                end
            end
            ST_DECODE: begin
                op_d = ir_op;
                case (ir_op)
                    OP_HLT:  state_d = ST_HALT;
                    OP_NOP:  state_d = ST_FETCH;
                    OP_JMP:  state_d = ST_FETCH;
                    default: state_d = ST_MEM;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_STA) ? ST_FETCH : ST_WB;
                end else if (wait_timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wait_en = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: Moore on state, except the fetch/jump strobes which also
    // look at mem_ready / ir_op in the current cycle.
    always_comb begin
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        ir_load  = 1'b0;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        acc_load = 1'b0;
        alu_op   = ALU_ADD;
        halt     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                addr_sel = 1'b0;
                mem_rd   = 1'b1;
                ir_load  = mem_ready;
                pc_en    = mem_ready;
            end
            ST_DECODE: begin
                pc_load = (ir_op == OP_JMP);
            end
            ST_MEM: begin
                addr_sel = 1'b1;
                alu_op   = alu_of_op(op_q);
                if (op_q == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
            end
            ST_WB: begin
                acc_load = 1'b1;
                alu_op   = alu_of_op(op_q);
            end
            ST_HALT: begin
                halt = 1'b1;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Testbench for cpu_ctrl_fsm: a vector table of per-cycle inputs and
// expected outputs, plus hand-written timeout and reset sequences.
module tb_cpu_ctrl_fsm;

    logic       clock;
    logic       reset;
    logic       start;
    logic [2:0] ir_op;
    logic       mem_ready;
    logic       pc_en;
    logic       pc_load;
    logic       ir_load;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       halt;
    logic       bus_err;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    // Expected output word: {pc_en,pc_load,ir_load,addr_sel,mem_rd,mem_wr,
    //                        acc_load,alu_op[1:0],halt,bus_err,state[2:0]}
    logic [13:0] exp_q[$];

    typedef struct packed {
        logic        start;
        logic [2:0]  op;
        logic        rdy;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[$];

    cpu_ctrl_fsm #(
        .OPW      (3),
        .WAIT_MAX (15),
        .CW       (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ir_op     (ir_op),
        .mem_ready (mem_ready),
        .pc_en     (pc_en),
        .pc_load   (pc_load),
        .ir_load   (ir_load),
        .addr_sel  (addr_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .acc_load  (acc_load),
        .alu_op    (alu_op),
        .halt      (halt),
        .bus_err   (bus_err),
        .state     (state)
    );

    // Clock generation.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] ow(input logic [2:0] st, input logic pe, input logic pl,
                                       input logic il, input logic as, input logic rd,
                                       input logic wr, input logic al, input logic [1:0] alu,
                                       input logic h, input logic be);
        return {pe, pl, il, as, rd, wr, al, alu, h, be, st};
    endfunction

    function automatic logic [13:0] o_idle();
        return ow(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [13:0] o_fetch(input logic rdy);
        return ow(3'd1, rdy, 0, rdy, 0, 1, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [13:0] o_dec(input logic pl);
        return ow(3'd2, 0, pl, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [13:0] o_memrd(input logic [1:0] alu);
        return ow(3'd3, 0, 0, 0, 1, 1, 0, 0, alu, 0, 0);
    endfunction
    function automatic logic [13:0] o_memwr();
        return ow(3'd3, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0);
    endfunction
    function automatic logic [13:0] o_wb(input logic [1:0] alu);
        return ow(3'd4, 0, 0, 0, 0, 0, 0, 1, alu, 0, 0);
    endfunction
    function automatic logic [13:0] o_halt(input logic be);
        return ow(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, be);
    endfunction

    function automatic vec_t mk(input logic s, input logic [2:0] op, input logic rdy,
                                input logic [13:0] e);
        vec_t v;
        v.start = s;
        v.op    = op;
        v.rdy   = rdy;
        v.exp   = e;
        return v;
    endfunction

    function automatic logic [13:0] act_word();
        return {pc_en, pc_load, ir_load, addr_sel, mem_rd, mem_wr, acc_load,
                alu_op, halt, bus_err, state};
    endfunction

    // Pop the oldest expectation and compare it with the live outputs.
    task automatic check_out(input string nm);
        logic [13:0] e;
        logic [13:0] a;
        e = exp_q.pop_front();
        a = act_word();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s @%0t: got %b required %b", nm, $time, a, e);
        end
        checks++;
        if ((pc_en && pc_load) || (mem_rd && mem_wr)) begin
            failures++;
            $display("FAIL %s_exclusive @%0t: pc_en=%b pc_load=%b mem_rd=%b mem_wr=%b required no overlap",
                     nm, $time, pc_en, pc_load, mem_rd, mem_wr);
        end
    endtask

    // Drive one cycle of inputs just after the edge, check mid-cycle.
    task automatic step(input vec_t v, input string nm);
        @(posedge clock);
        #1;
        start     = v.start;
        ir_op     = v.op;
        mem_ready = v.rdy;
        exp_q.push_back(v.exp);
        @(negedge clock);
        check_out(nm);
    endtask

    // Hold reset for a cycle, check the reset outputs, release on a falling edge.
    task automatic do_reset();
        reset     = 1'b0;
        start     = 1'b0;
        ir_op     = 3'b000;
        mem_ready = 1'b0;
        @(posedge clock);
        #1;
        exp_q.push_back(o_idle());
        check_out("reset_hold");
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        ir_op     = 3'b000;
        mem_ready = 1'b0;

        // Idle for 10 cycles, then start.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 3'b000, 0, o_idle()));
        tbl.push_back(mk(1, 3'b000, 0, o_idle()));
        // ADD, SUB, AND, LDA with zero wait states.
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b001, 1, o_dec(0)));
        tbl.push_back(mk(0, 3'b000, 1, o_memrd(2'b00)));
        tbl.push_back(mk(0, 3'b000, 0, o_wb(2'b00)));
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b010, 1, o_dec(0)));
        tbl.push_back(mk(0, 3'b000, 1, o_memrd(2'b01)));
        tbl.push_back(mk(0, 3'b000, 0, o_wb(2'b01)));
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b011, 1, o_dec(0)));
        tbl.push_back(mk(0, 3'b000, 1, o_memrd(2'b10)));
        tbl.push_back(mk(0, 3'b000, 0, o_wb(2'b10)));
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b100, 1, o_dec(0)));
        tbl.push_back(mk(0, 3'b000, 1, o_memrd(2'b11)));
        tbl.push_back(mk(0, 3'b000, 0, o_wb(2'b11)));
        // STA with two wait states.
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b101, 1, o_dec(0)));
        tbl.push_back(mk(0, 3'b000, 0, o_memwr()));
        tbl.push_back(mk(0, 3'b000, 0, o_memwr()));
        tbl.push_back(mk(0, 3'b000, 1, o_memwr()));
        // JMP then NOP.
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b110, 1, o_dec(1)));
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b111, 1, o_dec(0)));
        // Fetch and data access each with wait states.
        tbl.push_back(mk(0, 3'b000, 0, o_fetch(0)));
        tbl.push_back(mk(0, 3'b000, 0, o_fetch(0)));
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b001, 0, o_dec(0)));
        tbl.push_back(mk(0, 3'b000, 0, o_memrd(2'b00)));
        tbl.push_back(mk(0, 3'b000, 1, o_memrd(2'b00)));
        tbl.push_back(mk(0, 3'b000, 0, o_wb(2'b00)));
        // HLT: absorbing, start ignored, no bus error.
        tbl.push_back(mk(0, 3'b000, 1, o_fetch(1)));
        tbl.push_back(mk(0, 3'b000, 1, o_dec(0)));
        tbl.push_back(mk(1, 3'b000, 0, o_halt(0)));
        tbl.push_back(mk(0, 3'b000, 0, o_halt(0)));
        tbl.push_back(mk(1, 3'b111, 1, o_halt(0)));
        tbl.push_back(mk(0, 3'b000, 1, o_halt(0)));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Fetch timeout: 16 cycles without ready faults into HALT with bus_err.
        do_reset();
        step(mk(1, 3'b000, 0, o_idle()), "to_start");
        for (int i = 0; i < 16; i++) step(mk(0, 3'b000, 0, o_fetch(0)), "to_fetch_wait");
        step(mk(0, 3'b000, 0, o_halt(1)), "to_fetch_halt");
        step(mk(1, 3'b000, 1, o_halt(1)), "to_fetch_absorb");

        // Ready on the timeout cycle wins; then a MEM-phase timeout.
        do_reset();
        step(mk(1, 3'b000, 0, o_idle()), "edge_start");
        for (int i = 0; i < 15; i++) step(mk(0, 3'b000, 0, o_fetch(0)), "edge_fetch_wait");
        step(mk(0, 3'b000, 1, o_fetch(1)), "edge_fetch_ready");
        step(mk(0, 3'b001, 0, o_dec(0)), "edge_decode");
        for (int i = 0; i < 16; i++) step(mk(0, 3'b000, 0, o_memrd(2'b00)), "mem_wait");
        step(mk(0, 3'b000, 0, o_halt(1)), "mem_timeout_halt");

        // Reset asserted in the middle of a MEM cycle.
        do_reset();
        step(mk(1, 3'b000, 0, o_idle()), "rst_start");
        step(mk(0, 3'b000, 1, o_fetch(1)), "rst_fetch");
        step(mk(0, 3'b100, 0, o_dec(0)), "rst_decode");
        step(mk(0, 3'b000, 0, o_memrd(2'b11)), "rst_mem");
        #1;
        reset = 1'b0;
        #1;
        exp_q.push_back(o_idle());
        check_out("rst_async");
        @(negedge clock);
        reset = 1'b1;
        step(mk(0, 3'b000, 1, o_idle()), "rst_after");
        step(mk(1, 3'b000, 1, o_idle()), "rst_restart");
        step(mk(0, 3'b000, 1, o_fetch(1)), "rst_refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
